// File: rtl/enc_lock_pkg.sv
// enc_lock_pkg: shared types, sizes and helpers for the encoder combination lock.
package enc_lock_pkg;
    localparam int DIGIT_W = 4;
    localparam int NUM_DIGITS = 4;
    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_FAIL,
        ST_LOCKOUT
    } state_e;

    function automatic logic [DIGIT_W-1:0] code_digit(logic [DIGIT_W*NUM_DIGITS-1:0] code, logic [1:0] i);
        return code[DIGIT_W*(NUM_DIGITS-1-int'(i)) +: DIGIT_W];
    endfunction

    // Timer sized for the longest interval it must count; TIMER_W is the fallback.
    function automatic int tmr_width(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : TIMER_W;
    endfunction
endpackage

// File: rtl/enc_lock_if.sv
// enc_lock_if: encoder/button inputs and lock status outputs of enc_lock_ctrl.
interface enc_lock_if
    import enc_lock_pkg::*;
;
    logic [DIGIT_W-1:0] enc;
    logic               pb;
    logic               unlocked;
    logic               fail;
    logic               lockout;
    logic [1:0]         digit_idx;
    logic [2:0]         tries;

    modport master (output enc, pb, input unlocked, fail, lockout, digit_idx, tries);
    modport slave (input enc, pb, output unlocked, fail, lockout, digit_idx, tries);
endinterface

// File: rtl/enc_lock_timer.sv
// enc_lock_timer: loadable down-counter, done while the count sits at zero.
module enc_lock_timer
    import enc_lock_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? load_val : ((cnt_q != '0) ? cnt_q - 1'b1 : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/enc_lock_ctrl.sv
// enc_lock_ctrl: four-digit rotary-encoder combination lock with retry lockout.
// Defining ENC_LOCK_TIMEOUT_EN adds an inactivity timeout for partial entries.
module enc_lock_ctrl
    import enc_lock_pkg::*;
#(
    parameter logic [15:0] CODE        = 16'h1234,
    parameter int          MAX_TRIES   = 3,
    parameter int          OPEN_CYC    = 1000,
    parameter int          LOCKOUT_CYC = 5000,
    parameter int          TIMEOUT_CYC = 2000
) (
    input logic       clk,
    input logic       rst,
    enc_lock_if.slave bus
);
    localparam int TW = tmr_width(OPEN_CYC, LOCKOUT_CYC, TIMEOUT_CYC);
    localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYC - 1);
    localparam logic [2:0]    MAX_T   = 3'(MAX_TRIES);
`ifdef ENC_LOCK_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYC - 1);
`endif

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] tries_q, tries_d;
    logic       match_q, match_d;
    logic       pb_q, pb_d;
    logic       unlocked_q, unlocked_d;
    logic       fail_q, fail_d;
    logic       lockout_q, lockout_d;
    logic          tmr_load, tmr_done, press, hit;
    logic [TW-1:0] tmr_val;

    assign press = bus.pb && !pb_q;
    assign hit   = (bus.enc == code_digit(CODE, idx_q));
    assign pb_d  = bus.pb;

    enc_lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tries_d  = tries_q;
        match_d  = match_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_ENTRY: begin
                if (press) begin
                    idx_d   = idx_q + 2'd1;
                    match_d = match_q && hit;
`ifdef ENC_LOCK_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TO_LD;
`endif
                    if (idx_q == 2'd3) begin
                        match_d  = 1'b1;
                        state_d  = (match_q && hit) ? ST_OPEN : ST_FAIL;
                        tries_d  = (match_q && hit) ? 3'd0 : ((tries_q == MAX_T) ? tries_q : tries_q + 3'd1);
                        tmr_load = 1'b1;
                        tmr_val  = OPEN_LD;
                    end
                end
`ifdef ENC_LOCK_TIMEOUT_EN
                else if (idx_q != 2'd0 && tmr_done) begin
                    idx_d   = 2'd0;
                    match_d = 1'b1;
                end
`endif
            end
            ST_OPEN: begin
                tries_d = 3'd0;
                state_d = (press || tmr_done) ? ST_ENTRY : ST_OPEN;
            end
            ST_FAIL: begin
                state_d  = (tries_q == MAX_T) ? ST_LOCKOUT : ST_ENTRY;
                tmr_load = (tries_q == MAX_T);
                tmr_val  = LOCK_LD;
            end
            ST_LOCKOUT: begin
                state_d = tmr_done ? ST_ENTRY : ST_LOCKOUT;
                tries_d = tmr_done ? 3'd0 : tries_q;
            end
        endcase
        unlocked_d = (state_d == ST_OPEN);
        fail_d     = (state_d == ST_FAIL);
        lockout_d  = (state_d == ST_LOCKOUT);
    end

    // pb_q resets high so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ENTRY;
            idx_q      <= 2'd0;
            tries_q    <= 3'd0;
            match_q    <= 1'b1;
            pb_q       <= 1'b1;
            unlocked_q <= 1'b0;
            fail_q     <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tries_q    <= tries_d;
            match_q    <= match_d;
            pb_q       <= pb_d;
            unlocked_q <= unlocked_d;
            fail_q     <= fail_d;
            lockout_q  <= lockout_d;
        end
    end

    assign bus.unlocked  = unlocked_q;
    assign bus.fail      = fail_q;
    assign bus.lockout   = lockout_q;
    assign bus.digit_idx = idx_q;
    assign bus.tries     = tries_q;
endmodule

// File: tb/tb_enc_lock_ctrl.sv
// tb_enc_lock_ctrl: vector table, directed corner sequences and random stimulus
// checked against a digit-queue reference model of the combination lock.
module tb_enc_lock_ctrl;
    localparam logic [15:0] CODE        = 16'h1234;
    localparam int          MAX_TRIES   = 3;
    localparam int          OPEN_CYC    = 1000;
    localparam int          LOCKOUT_CYC = 5000;
    localparam int          TIMEOUT_CYC = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    enc_lock_if bus();

    enc_lock_ctrl #(
        .CODE(CODE), .MAX_TRIES(MAX_TRIES), .OPEN_CYC(OPEN_CYC),
        .LOCKOUT_CYC(LOCKOUT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: digits entered so far, remaining open/lockout cycles.
    int m_digs[$];
    int m_open = 0;
    int m_lock = 0;
    bit m_fail = 0;
    int m_tries = 0;
    bit m_pbq = 1;
    int m_idle = 0;

    function automatic int code_dig(int k);
        return (int'(CODE) >> (4 * (3 - k))) & 15;
    endfunction

    task automatic model_step(input bit r, input bit p, input logic [3:0] e);
        bit press;
        int val;
        press = p && !m_pbq;
        m_pbq = r ? 1'b1 : p;
        if (r) begin
            m_digs.delete();
            m_open = 0; m_lock = 0; m_fail = 0; m_tries = 0; m_idle = 0;
        end else if (m_fail) begin
            m_fail = 0;
            if (m_tries == MAX_TRIES) m_lock = LOCKOUT_CYC;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_tries = 0;
        end else if (m_open > 0) begin
            m_open = press ? 0 : m_open - 1;
        end else if (press) begin
            m_digs.push_back(int'(e));
            m_idle = 0;
            if (m_digs.size() == 4) begin
                val = (m_digs[0] << 12) | (m_digs[1] << 8) | (m_digs[2] << 4) | m_digs[3];
                if (val == int'(CODE)) begin
                    m_open = OPEN_CYC;
                    m_tries = 0;
                end else begin
                    m_fail = 1;
                    if (m_tries < MAX_TRIES) m_tries++;
                end
                m_digs.delete();
            end
        end else if (m_digs.size() > 0) begin
`ifdef ENC_LOCK_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT_CYC) m_digs.delete();
`endif
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit p, input logic [3:0] e);
        rst = r;
        bus.pb = p;
        bus.enc = e;
        @(posedge clk);
        model_step(r, p, e);
        #1;
        check("unlocked", int'(bus.unlocked), int'(m_open > 0));
        check("fail", int'(bus.fail), int'(m_fail));
        check("lockout", int'(bus.lockout), int'(m_lock > 0));
        check("digit_idx", int'(bus.digit_idx), m_digs.size());
        check("tries", int'(bus.tries), m_tries);
    endtask

    task automatic press(input logic [3:0] e);
        cyc(0, 1, e);
        cyc(0, 0, e);
    endtask

    typedef struct {
        bit r; bit p; logic [3:0] e;
        bit u; bit f; bit l; int idx; int tr;
    } vec_t;
    vec_t tbl[14];

    initial begin
        int cnt;
        int fails;
        bit p;
        bus.pb = 1'b0;
        bus.enc = 4'd0;
        tbl[0]  = '{1, 0, 4'd0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 4'd0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 4'd1, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 4'd1, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 1, 4'd2, 0, 0, 0, 2, 0};
        tbl[5]  = '{0, 0, 4'd2, 0, 0, 0, 2, 0};
        tbl[6]  = '{0, 1, 4'd3, 0, 0, 0, 3, 0};
        tbl[7]  = '{0, 0, 4'd3, 0, 0, 0, 3, 0};
        tbl[8]  = '{0, 1, 4'd5, 0, 1, 0, 0, 1};
        tbl[9]  = '{0, 0, 4'd5, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 1, 4'd1, 0, 0, 0, 1, 1};
        tbl[11] = '{0, 1, 4'd2, 0, 0, 0, 1, 1};
        tbl[12] = '{0, 1, 4'd7, 0, 0, 0, 1, 1};
        tbl[13] = '{0, 0, 4'd7, 0, 0, 0, 1, 1};
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].p, tbl[i].e);
            check($sformatf("tbl%0d_unlocked", i), int'(bus.unlocked), int'(tbl[i].u));
            check($sformatf("tbl%0d_fail", i), int'(bus.fail), int'(tbl[i].f));
            check($sformatf("tbl%0d_lockout", i), int'(bus.lockout), int'(tbl[i].l));
            check($sformatf("tbl%0d_idx", i), int'(bus.digit_idx), tbl[i].idx);
            check($sformatf("tbl%0d_tries", i), int'(bus.tries), tbl[i].tr);
        end

        // Correct code opens for exactly OPEN_CYC cycles.
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        press(1); press(2); press(3);
        cyc(0, 1, 4);
        check("open_unlocked", int'(bus.unlocked), 1);
        check("open_tries", int'(bus.tries), 0);
        cnt = int'(bus.unlocked);
        for (int i = 0; i < 1100; i++) begin
            cyc(0, 0, 0);
            cnt += int'(bus.unlocked);
        end
        check("open_len", cnt, OPEN_CYC);

        // A press while open closes the lock and is not taken as a digit.
        press(1); press(2); press(3); press(4);
        cyc(0, 1, 4'd9);
        check("open_press_unlocked", int'(bus.unlocked), 0);
        check("open_press_idx", int'(bus.digit_idx), 0);
        cyc(0, 0, 0);

        // Three wrong codes lock out; presses during lockout are ignored.
        for (int k = 0; k < 3; k++) begin
            press(1); press(1); press(1); press(1);
        end
        check("lock_after3", int'(bus.lockout), 1);
        check("lock_tries", int'(bus.tries), MAX_TRIES);
        cnt = int'(bus.lockout);
        for (int i = 0; i < 5100; i++) begin
            cyc(0, (i < 4900) && (i % 7 == 0), 4'($urandom_range(0, 15)));
            cnt += int'(bus.lockout);
        end
        check("lock_len", cnt, LOCKOUT_CYC);
        check("lock_exit_tries", int'(bus.tries), 0);
        check("lock_exit_idx", int'(bus.digit_idx), 0);
        press(1); press(2); press(3);
        cyc(0, 1, 4);
        check("lock_then_open", int'(bus.unlocked), 1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);

        // Reset after two digits with pb held through the release of reset.
        press(1);
        cyc(0, 1, 2);
        cyc(1, 1, 2);
        cyc(0, 1, 2);
        check("rst_held_idx", int'(bus.digit_idx), 0);
        cyc(0, 1, 2);
        cyc(0, 0, 2);
        check("rst_held_idx2", int'(bus.digit_idx), 0);

        // Partial entry followed by a long idle period.
        press(1); press(2);
        fails = 0;
        for (int i = 0; i < TIMEOUT_CYC + 10; i++) begin
            cyc(0, 0, 0);
            fails += int'(bus.fail);
        end
`ifdef ENC_LOCK_TIMEOUT_EN
        check("idle_idx", int'(bus.digit_idx), 0);
`else
        check("idle_idx", int'(bus.digit_idx), 2);
`endif
        check("idle_no_fail", fails, 0);
        check("idle_tries", int'(bus.tries), 0);

        // Random stimulus, half the digits steered toward the code.
        cyc(1, 0, 0);
        p = 0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 2) == 0) p = !p;
            cyc($urandom_range(0, 1999) == 0, p,
                ($urandom_range(0, 1) == 1) ? 4'(code_dig(m_digs.size())) : 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
